// File: rtl/sy_tl_demux.sv
// sy_tl_demux: single-upstream, multi-downstream TileLink request router.
//
// Decodes each upstream A-channel request by address and forwards it to exactly
// one downstream slave (lowest matching index wins). D responses come back
// from the slave that owns the outstanding transactions. Only one target may
// have requests in flight at a time, so responses return in order without a
// reorder buffer.
//
// Optional feature (compile-time macro SY_TL_DEMUX_ERR_SLAVE_EN):
//   defined     - unmapped requests go to an internal error slave (index NSLV)
//                 that answers one cycle later with AccessAckData, denied=1,
//                 data=0, one request at a time.
//   not defined - unmapped requests route to slave 0.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   up_a_*               upstream A channel (valid/ready, opcode, address, data)
//   up_d_*               upstream D channel (valid/ready, opcode, denied, data)
//   up_b_valid_o         upstream B channel valid, tied low
//   dn_a_valid_o/ready_i per-slave A handshake; dn_a_opcode/address/data broadcast
//   dn_d_*               per-slave D channel (valid/ready, opcode, denied, data)
module sy_tl_demux #(
  parameter int unsigned NSLV       = 2,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_OUT    = 4,
  parameter logic [ADDR_WIDTH-1:0] SLV_BASE [NSLV] = '{64'h0000_0000_0001_0000,
                                                       64'h0000_0000_0200_0000},
  parameter logic [ADDR_WIDTH-1:0] SLV_MASK [NSLV] = '{64'hFFFF_FFFF_FFFF_0000,
                                                       64'hFFFF_FFFF_FFF0_0000}
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  // Upstream
  input  logic                             up_a_valid_i,
  output logic                             up_a_ready_o,
  input  logic [2:0]                       up_a_opcode_i,
  input  logic [ADDR_WIDTH-1:0]            up_a_address_i,
  input  logic [DATA_WIDTH-1:0]            up_a_data_i,
  output logic                             up_d_valid_o,
  input  logic                             up_d_ready_i,
  output logic [2:0]                       up_d_opcode_o,
  output logic                             up_d_denied_o,
  output logic [DATA_WIDTH-1:0]            up_d_data_o,
  output logic                             up_b_valid_o,
  // Downstream
  output logic [NSLV-1:0]                  dn_a_valid_o,
  input  logic [NSLV-1:0]                  dn_a_ready_i,
  output logic [2:0]                       dn_a_opcode_o,
  output logic [ADDR_WIDTH-1:0]            dn_a_address_o,
  output logic [DATA_WIDTH-1:0]            dn_a_data_o,
  input  logic [NSLV-1:0]                  dn_d_valid_i,
  output logic [NSLV-1:0]                  dn_d_ready_o,
  input  logic [NSLV-1:0][2:0]             dn_d_opcode_i,
  input  logic [NSLV-1:0]                  dn_d_denied_i,
  input  logic [NSLV-1:0][DATA_WIDTH-1:0]  dn_d_data_i
);

`ifdef SY_TL_DEMUX_ERR_SLAVE_EN
  localparam int unsigned NTGT = NSLV + 1;
`else
  localparam int unsigned NTGT = NSLV;
`endif
  localparam int unsigned SelW = (NTGT > 1) ? $clog2(NTGT) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0] cur_sel_q, cur_sel_d;
  logic [SelW-1:0] tgt;
  logic            tgt_ready;
  logic            stall;
  logic            src_d_valid;
  logic            a_hs, d_hs;

`ifdef SY_TL_DEMUX_ERR_SLAVE_EN
  localparam logic [SelW-1:0] ErrSel        = SelW'(NSLV);
  localparam logic [2:0]      AccessAckData = 3'd1;

  logic err_pend_q, err_pend_d;
  logic err_ready;

  // One error transaction at a time: free only when idle or its response is gone.
  assign err_ready = (cnt_q == '0) | ((cur_sel_q == ErrSel) & ~err_pend_q);
`endif

  // Address decode; scanning downwards lets the lowest index win on overlap.
  always_comb begin
`ifdef SY_TL_DEMUX_ERR_SLAVE_EN
    tgt = ErrSel;
`else
    tgt = '0;
`endif
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((up_a_address_i & SLV_MASK[i]) == SLV_BASE[i]) begin
        tgt = SelW'(i);
      end
    end
  end

  // Hold new requests while full, or while another target still owes responses.
  assign stall = (cnt_q == CntW'(MAX_OUT)) | ((cnt_q != '0) & (tgt != cur_sel_q));

  // A path: purely combinational routing, address/data broadcast.
  always_comb begin
    tgt_ready = 1'b0;
`ifdef SY_TL_DEMUX_ERR_SLAVE_EN
    if (tgt == ErrSel) begin
      tgt_ready = err_ready;
    end
`endif
    for (int i = 0; i < int'(NSLV); i++) begin
      if (tgt == SelW'(i)) begin
        tgt_ready = dn_a_ready_i[i];
      end
    end
    up_a_ready_o = rst_ni & tgt_ready & ~stall;
    for (int i = 0; i < int'(NSLV); i++) begin
      dn_a_valid_o[i] = rst_ni & up_a_valid_i & ~stall & (tgt == SelW'(i));
    end
  end

  assign dn_a_opcode_o  = up_a_opcode_i;
  assign dn_a_address_o = up_a_address_i;
  assign dn_a_data_o    = up_a_data_i;

  // D path: mux from the current owner; valid gated by the outstanding count so
  // stale responses after reset never reach upstream.
  always_comb begin
    src_d_valid   = 1'b0;
    up_d_opcode_o = '0;
    up_d_denied_o = 1'b0;
    up_d_data_o   = '0;
`ifdef SY_TL_DEMUX_ERR_SLAVE_EN
    if (cur_sel_q == ErrSel) begin
      src_d_valid   = err_pend_q;
      up_d_opcode_o = AccessAckData;
      up_d_denied_o = 1'b1;
      up_d_data_o   = '0;
    end
`endif
    for (int i = 0; i < int'(NSLV); i++) begin
      dn_d_ready_o[i] = up_d_ready_i & (cur_sel_q == SelW'(i));
      if (cur_sel_q == SelW'(i)) begin
        src_d_valid   = dn_d_valid_i[i];
        up_d_opcode_o = dn_d_opcode_i[i];
        up_d_denied_o = dn_d_denied_i[i];
        up_d_data_o   = dn_d_data_i[i];
      end
    end
    up_d_valid_o = rst_ni & (cnt_q != '0) & src_d_valid;
  end

  assign up_b_valid_o = 1'b0;

  assign a_hs = up_a_valid_i & up_a_ready_o;
  assign d_hs = up_d_valid_o & up_d_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (a_hs & ~d_hs) begin
      cnt_d = cnt_q + 1'b1;
    end else if (~a_hs & d_hs) begin
      cnt_d = cnt_q - 1'b1;
    end
    cur_sel_d = a_hs ? tgt : cur_sel_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      cur_sel_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
    end
  end

`ifdef SY_TL_DEMUX_ERR_SLAVE_EN
  always_comb begin
    err_pend_d = err_pend_q;
    if (d_hs & (cur_sel_q == ErrSel)) begin
      err_pend_d = 1'b0;
    end
    if (a_hs & (tgt == ErrSel)) begin
      err_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_pend_q <= 1'b0;
    end else begin
      err_pend_q <= err_pend_d;
    end
  end
`endif

endmodule

// File: doc/sy_tl_demux.md
# sy_tl_demux

Single-upstream, multi-downstream TileLink request router. It sits between the SoC TileLink crossbar port and a group of register-style slaves (boot ROM, CLINT, UART, …). It decodes each A-channel request by address, forwards it to exactly one slave and returns that slave's D-channel response upstream. It tracks outstanding transactions so responses come back in order to the same upstream port.

## Interface
Parameters:
- NSLV, default 2: number of downstream slaves (1..8).
- ADDR_WIDTH, default 64: address width; matches TL_BUS.
- DATA_WIDTH, default 64: data width; matches TL_BUS.
- MAX_OUT, default 4: maximum outstanding A-accepted, D-unreturned transactions (1..15).
- SLV_BASE, default {64'h0000_0000_0001_0000, 64'h0000_0000_0200_0000}: per-slave base, array [NSLV][ADDR_WIDTH].
- SLV_MASK, default {64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_FFF0_0000}: per-slave match mask.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- up  TL_BUS.Master  —  upstream port; block accepts A and drives D.
- dn[NSLV]  TL_BUS.Slave  —  downstream ports; block drives A and accepts D.

## Operation
- Decode: slave i hits when (a_bits.address & SLV_MASK[i]) == SLV_BASE[i]. Lowest index wins on overlap. No hit means the request is unmapped.
- Routing: dn[sel].a_valid = up.a_valid & ~stall. All other dn[*].a_valid = 0. a_bits is broadcast to all slaves. up.a_ready = dn[sel].a_ready & ~stall.
- State registers:
  - cnt, width $clog2(MAX_OUT+1), counts outstanding transactions.
  - cur_sel, the target of the outstanding transactions.
  - err_pend, err_busy: error-responder state.
- stall is asserted when either:
  - cnt == MAX_OUT, or
  - cnt != 0 and the decoded target != cur_sel. This guarantees in-order D return with no reorder buffer.
- Count update, per cycle:
  - +1 on an A handshake (up.a_valid & up.a_ready).
  - −1 on a D handshake (up.d_valid & up.d_ready).
  - Both in the same cycle: cnt unchanged.
  - On an A handshake, cur_sel <= target.
- D path: up.d_valid = dn[cur_sel].d_valid when cnt != 0, else 0. up.d_bits = dn[cur_sel].d_bits. dn[cur_sel].d_ready = up.d_ready. All other dn[*].d_ready = 0.
- Unmapped-address behaviour depends on the configuration (see below).
- up.b_valid is tied to 0. dn[*].b_valid is ignored.

## Timing
- A path is combinational: zero-cycle latency, no A-side register.
- D path is combinational from dn[cur_sel].
- Total latency = slave latency.
- Error response, when enabled:
  - A accepted in cycle N produces d_valid in cycle N+1.
  - d_valid is held until d_ready is sampled.
- Reset values: cnt=0, cur_sel=0, err_pend=0. All dn a_valid=0, up.d_valid=0, up.a_ready=0.
- Handshake rules:
  - A request blocked by stall is held, not dropped. The upstream keeps a_valid and a_bits stable per TileLink.
  - A D response stalled by up.d_ready=0 leaves cnt unchanged.
- Asynchronous reset mid-transaction clears all tracking immediately. Any in-flight response arriving after reset is not forwarded, because cnt=0. Slaves are reset on the same rst_ni.
- cnt never underflows. A D handshake with cnt==0 is impossible, because d_valid is gated.

## Configuration
- SY_TL_DEMUX_ERR_SLAVE_EN defined:
  - An internal error slave (index NSLV) takes unmapped requests.
  - It accepts only when cnt==0, or when cur_sel==NSLV and err_pend==0. It handles one request at a time.
  - It responds one cycle later with d_bits.opcode=AccessAckData, d_bits.denied=1, d_bits.data=0.
  - cur_sel width covers NSLV+1 targets.
- Not defined: unmapped requests route to slave 0. There is no error logic, and cur_sel covers NSLV targets.

## Test plan
- Basic read to ROM: read 0x0001_0008, slave 0 returns data 0x1234 after 1 cycle. Expect dn[0].a_valid in the same cycle, up.d_bits.data=0x1234, and cnt back to 0.
- Back-to-back same slave: 4 reads to 0x0001_0000..0x18 with d_ready=0. Expect all 4 accepted, the 5th stalled (up.a_ready=0). Releasing d_ready drains the responses in order.
- Cross-slave ordering: a read to slave 0 is outstanding, then a read to 0x0200_0000 is presented. Expect it stalled until slave 0's D handshake, then forwarded to dn[1] in the same cycle cnt becomes 0.
- Simultaneous A and D handshake with cnt=2: expect cnt stays 2 and cur_sel is unchanged.
- Unmapped 0x8000_0000:
  - With the macro: d_valid one cycle after acceptance, denied=1, data=0.
  - Without the macro: the request appears on dn[0].
- Reset with cnt=3: deassert rst_ni mid-burst. Expect cnt=0, up.d_valid=0 and up.a_ready=0 immediately. A fresh read after reset completes normally.
